mtstb_sync_chain: RTL and testbench

// Parametrised N-stage synchroniser for an asynchronous multi-bit bus, sampled in the destination clock domain.

---
 rtl/mtstb_sync_chain.sv | 110 +++++++++++
 tb/tb_mtstb_sync_chain.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mtstb_sync_chain.sv
// Destination-domain N-stage synchroniser for an asynchronous bus, with optional Gray decode,
// change/multi-bit-change detection, and a simulation-only metastability imitation at the capture stage.
module mtstb_sync_chain #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int MTSTB_PCT = 20,
    parameter int GRAY_MODE = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [WIDTH-1:0]     async_value_i,
    input  logic                 mtstb_en_i,
    input  logic                 clr_cnt_i,
    output logic [WIDTH-1:0]     sync_value_o,
    output logic [WIDTH-1:0]     sync_bin_o,
    output logic                 changed_o,
    output logic                 multi_bit_err_o,
    output logic [CNT_WIDTH-1:0] mtstb_cnt_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] ideal_q;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] prev_out;
    logic [WIDTH-1:0] chain_q [STAGES-1];
    logic             multi_bit;

    assign delta     = async_value_i ^ ideal_q;
    assign multi_bit = $countones(delta) > 1;

`ifndef SYNTHESIS
    function automatic logic [WIDTH-1:0] rand_bits();
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction
`endif

    // Capture stage; the random draw is only taken when some input bit actually moved.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cap_q       <= '0;
            mtstb_cnt_o <= '0;
        end else begin
            cap_q <= async_value_i;
            if (clr_cnt_i) mtstb_cnt_o <= '0;
`ifndef SYNTHESIS
            if (mtstb_en_i && (|delta) && (MTSTB_PCT > int'($urandom_range(0, 99)))) begin
                cap_q <= (async_value_i & ~delta) | (rand_bits() & delta);
                if (!clr_cnt_i && mtstb_cnt_o != CNT_MAX) mtstb_cnt_o <= mtstb_cnt_o + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < STAGES-1; k++) chain_q[k] <= '0;
        end else begin
            chain_q[0] <= cap_q;
            for (int k = 1; k < STAGES-1; k++) chain_q[k] <= chain_q[k-1];
        end
    end

    assign sync_value_o = chain_q[STAGES-2];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ideal_q         <= '0;
            prev_out        <= '0;
            multi_bit_err_o <= 1'b0;
            err_cnt_o       <= '0;
        end else begin
            ideal_q         <= async_value_i;
            prev_out        <= sync_value_o;
            multi_bit_err_o <= multi_bit;
            if (clr_cnt_i)
                err_cnt_o <= '0;
            else if (multi_bit && err_cnt_o != CNT_MAX)
                err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

    assign changed_o = |(sync_value_o ^ prev_out);

    generate
        if (GRAY_MODE != 0) begin : g_gray
            always_comb begin
                sync_bin_o = '0;
                for (int i = 0; i < WIDTH; i++) sync_bin_o[i] = ^(sync_value_o >> i);
            end
        end else begin : g_bin
            assign sync_bin_o = sync_value_o;
        end
    endgenerate

`ifndef SYNTHESIS
    // A Gray-coded source must never move more than one bit between samples.
    always @(posedge clk_i) begin
        if (GRAY_MODE != 0 && rstn_i)
            assert (!multi_bit)
            else $error("gray-code violation: %0d bits changed in one sample", $countones(delta));
    end
`endif

endmodule

// File: tb/tb_mtstb_sync_chain.sv
// Bench for mtstb_sync_chain: three instances (metastable binary, ideal 3-stage with 2-bit counters,
// Gray decode) driven from one clock, checked against fixed expectations and a history-queue model.
module tb_mtstb_sync_chain;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  a_in = '0, a_sync, a_bin;
    logic        a_en = 1'b1, a_clr = 1'b0, a_chg, a_merr;
    logic [15:0] a_mcnt, a_ecnt;

    logic [3:0]  b_in = '0, b_sync, b_bin;
    logic        b_en = 1'b1, b_clr = 1'b0, b_chg, b_merr;
    logic [1:0]  b_mcnt, b_ecnt;

    logic [3:0]  g_in = '0, g_sync, g_bin;
    logic        g_en = 1'b1, g_clr = 1'b0, g_chg, g_merr;
    logic [15:0] g_mcnt, g_ecnt;

    mtstb_sync_chain #(.WIDTH(4), .STAGES(2), .MTSTB_PCT(100), .GRAY_MODE(0), .CNT_WIDTH(16)) u_a (
        .clk_i(clk), .rstn_i(rstn), .async_value_i(a_in), .mtstb_en_i(a_en), .clr_cnt_i(a_clr),
        .sync_value_o(a_sync), .sync_bin_o(a_bin), .changed_o(a_chg), .multi_bit_err_o(a_merr),
        .mtstb_cnt_o(a_mcnt), .err_cnt_o(a_ecnt));

    mtstb_sync_chain #(.WIDTH(4), .STAGES(3), .MTSTB_PCT(0), .GRAY_MODE(0), .CNT_WIDTH(2)) u_b (
        .clk_i(clk), .rstn_i(rstn), .async_value_i(b_in), .mtstb_en_i(b_en), .clr_cnt_i(b_clr),
        .sync_value_o(b_sync), .sync_bin_o(b_bin), .changed_o(b_chg), .multi_bit_err_o(b_merr),
        .mtstb_cnt_o(b_mcnt), .err_cnt_o(b_ecnt));

    mtstb_sync_chain #(.WIDTH(4), .STAGES(2), .MTSTB_PCT(100), .GRAY_MODE(1), .CNT_WIDTH(16)) u_g (
        .clk_i(clk), .rstn_i(rstn), .async_value_i(g_in), .mtstb_en_i(g_en), .clr_cnt_i(g_clr),
        .sync_value_o(g_sync), .sync_bin_o(g_bin), .changed_o(g_chg), .multi_bit_err_o(g_merr),
        .mtstb_cnt_o(g_mcnt), .err_cnt_o(g_ecnt));

    task automatic test_reset();
        logic seen_chg;
        rstn = 1'b0; a_in = 4'hF; a_en = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (a_sync !== 4'h0) begin n_fail++; $display("FAIL rst_sync: got %h want 0", a_sync); end
        n_checks++; if (a_bin !== 4'h0) begin n_fail++; $display("FAIL rst_bin: got %h want 0", a_bin); end
        n_checks++; if (a_chg !== 1'b0) begin n_fail++; $display("FAIL rst_chg: got %b want 0", a_chg); end
        n_checks++; if (a_merr !== 1'b0) begin n_fail++; $display("FAIL rst_merr: got %b want 0", a_merr); end
        n_checks++; if (a_mcnt !== 16'd0) begin n_fail++; $display("FAIL rst_mcnt: got %0d want 0", a_mcnt); end
        n_checks++; if (a_ecnt !== 16'd0) begin n_fail++; $display("FAIL rst_ecnt: got %0d want 0", a_ecnt); end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (a_merr !== 1'b1) begin n_fail++; $display("FAIL rel_merr: got %b want 1", a_merr); end
        n_checks++; if (a_mcnt !== 16'd1) begin n_fail++; $display("FAIL rel_mcnt: got %0d want 1", a_mcnt); end
        n_checks++; if (a_ecnt !== 16'd1) begin n_fail++; $display("FAIL rel_ecnt: got %0d want 1", a_ecnt); end
        @(negedge clk);
        seen_chg = a_chg;
        n_checks++; if (a_merr !== 1'b0) begin n_fail++; $display("FAIL rel_merr_end: got %b want 0", a_merr); end
        @(negedge clk);
        seen_chg |= a_chg;
        n_checks++; if (a_sync !== 4'hF) begin n_fail++; $display("FAIL rel_sync: got %h want F", a_sync); end
        n_checks++; if (a_bin !== 4'hF) begin n_fail++; $display("FAIL rel_bin: got %h want F", a_bin); end
        n_checks++; if (seen_chg !== 1'b1) begin n_fail++; $display("FAIL rel_chg_seen: got %b want 1", seen_chg); end
        n_checks++; if (a_mcnt !== 16'd1) begin n_fail++; $display("FAIL rel_mcnt_hold: got %0d want 1", a_mcnt); end
        @(negedge clk);
        n_checks++; if (a_chg !== 1'b0) begin n_fail++; $display("FAIL rel_chg_quiet: got %b want 0", a_chg); end
    endtask

    task automatic test_ideal_capture();
        a_en = 1'b0; a_in = 4'h3;
        @(negedge clk);
        n_checks++; if (a_sync !== 4'hF) begin n_fail++; $display("FAIL ideal_early: got %h want F", a_sync); end
        n_checks++; if (a_mcnt !== 16'd1) begin n_fail++; $display("FAIL ideal_mcnt: got %0d want 1", a_mcnt); end
        n_checks++; if (a_ecnt !== 16'd2) begin n_fail++; $display("FAIL ideal_ecnt: got %0d want 2", a_ecnt); end
        @(negedge clk);
        n_checks++; if (a_sync !== 4'h3) begin n_fail++; $display("FAIL ideal_sync: got %h want 3", a_sync); end
        n_checks++; if (a_chg !== 1'b1) begin n_fail++; $display("FAIL ideal_chg: got %b want 1", a_chg); end
    endtask

    task automatic test_latency();
        b_in = 4'h5;
        @(negedge clk);
        n_checks++; if (b_merr !== 1'b1) begin n_fail++; $display("FAIL lat_merr: got %b want 1", b_merr); end
        n_checks++; if (b_sync !== 4'h0) begin n_fail++; $display("FAIL lat_e0: got %h want 0", b_sync); end
        @(negedge clk);
        n_checks++; if (b_sync !== 4'h0) begin n_fail++; $display("FAIL lat_e1: got %h want 0", b_sync); end
        @(negedge clk);
        n_checks++; if (b_sync !== 4'h5) begin n_fail++; $display("FAIL lat_e2: got %h want 5", b_sync); end
        n_checks++; if (b_bin !== 4'h5) begin n_fail++; $display("FAIL lat_bin: got %h want 5", b_bin); end
        n_checks++; if (b_chg !== 1'b1) begin n_fail++; $display("FAIL lat_chg: got %b want 1", b_chg); end
        n_checks++; if (b_mcnt !== 2'd0) begin n_fail++; $display("FAIL lat_mcnt: got %0d want 0", b_mcnt); end
        n_checks++; if (b_ecnt !== 2'd1) begin n_fail++; $display("FAIL lat_ecnt: got %0d want 1", b_ecnt); end
        @(negedge clk);
        n_checks++; if (b_chg !== 1'b0) begin n_fail++; $display("FAIL lat_chg_quiet: got %b want 0", b_chg); end
    endtask

    task automatic test_gray();
        logic [3:0] n4, prev4;
        for (int n = 1; n < 16; n++) begin
            n4 = 4'(n); prev4 = 4'(n - 1);
            g_in = n4 ^ (n4 >> 1);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                n_checks++;
                if (g_bin !== prev4 && g_bin !== n4) begin
                    n_fail++; $display("FAIL gray_step: got %0d want %0d or %0d", g_bin, prev4, n4);
                end
            end
            n_checks++; if (g_bin !== n4) begin n_fail++; $display("FAIL gray_settle: got %0d want %0d", g_bin, n4); end
        end
        n_checks++; if (g_ecnt !== 16'd0) begin n_fail++; $display("FAIL gray_ecnt: got %0d want 0", g_ecnt); end
        n_checks++; if (g_mcnt !== 16'd15) begin n_fail++; $display("FAIL gray_mcnt: got %0d want 15", g_mcnt); end
        n_checks++; if (g_sync !== 4'b1000) begin n_fail++; $display("FAIL gray_sync: got %b want 1000", g_sync); end
    endtask

    task automatic test_multibit();
        int pulses;
        a_en = 1'b0; a_in = 4'b0111;
        repeat (3) @(negedge clk);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        n_checks++; if (a_ecnt !== 16'd0) begin n_fail++; $display("FAIL clr_ecnt: got %0d want 0", a_ecnt); end
        n_checks++; if (a_mcnt !== 16'd0) begin n_fail++; $display("FAIL clr_mcnt: got %0d want 0", a_mcnt); end
        n_checks++; if (a_sync !== 4'b0111) begin n_fail++; $display("FAIL mb_pre: got %b want 0111", a_sync); end
        a_en = 1'b1; a_in = 4'b1000;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pulses += int'(a_merr);
            if (i >= 2) begin
                n_checks++; if (a_sync !== 4'b1000) begin n_fail++; $display("FAIL mb_sync: got %b want 1000", a_sync); end
            end
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL mb_pulses: got %0d want 1", pulses); end
        n_checks++; if (a_mcnt !== 16'd1) begin n_fail++; $display("FAIL mb_mcnt: got %0d want 1", a_mcnt); end
        n_checks++; if (a_ecnt !== 16'd1) begin n_fail++; $display("FAIL mb_ecnt: got %0d want 1", a_ecnt); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt;
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        n_checks++; if (b_ecnt !== 2'd0) begin n_fail++; $display("FAIL sat_clr: got %0d want 0", b_ecnt); end
        for (int i = 1; i <= 5; i++) begin
            b_in = (i % 2 == 1) ? 4'hA : 4'h5;
            @(negedge clk);
            exp_cnt = (i < 3) ? 2'(i) : 2'd3;
            n_checks++; if (b_ecnt !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt: got %0d want %0d", b_ecnt, exp_cnt); end
        end
        b_in = 4'h5; b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        n_checks++; if (b_ecnt !== 2'd0) begin n_fail++; $display("FAIL sat_clr_evt: got %0d want 0", b_ecnt); end
        n_checks++; if (b_merr !== 1'b1) begin n_fail++; $display("FAIL sat_merr: got %b want 1", b_merr); end
        @(negedge clk);
        n_checks++; if (b_ecnt !== 2'd0) begin n_fail++; $display("FAIL sat_after: got %0d want 0", b_ecnt); end
        n_checks++; if (b_mcnt !== 2'd0) begin n_fail++; $display("FAIL sat_mcnt: got %0d want 0", b_mcnt); end
    endtask

    // Model: the synchronised value is simply the input sampled STAGES-1 edges earlier.
    task automatic test_random();
        logic [3:0] hist [$];
        logic [3:0] v, diff, exp_sync;
        logic       clr, exp_merr, exp_chg;
        int         bits, cnt;
        b_clr = 1'b1;
        repeat (4) @(negedge clk);
        b_clr = 1'b0;
        cnt = 0;
        hist = '{b_in, b_in, b_in, b_in};
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 1) == 0) v = hist[0] ^ (4'b0001 << $urandom_range(0, 3));
            else v = 4'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            b_in = v; b_clr = clr; b_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            hist.push_front(v);
            if (hist.size() > 6) void'(hist.pop_back());
            diff = hist[0] ^ hist[1];
            bits = 0;
            for (int i = 0; i < 4; i++) bits += int'(diff[i]);
            exp_merr = (bits > 1);
            if (clr) cnt = 0;
            else if (exp_merr && cnt < 3) cnt++;
            exp_sync = hist[2];
            exp_chg  = (hist[2] != hist[3]);
            n_checks++; if (b_sync !== exp_sync) begin n_fail++; $display("FAIL rnd_sync t=%0d: got %h want %h", t, b_sync, exp_sync); end
            n_checks++; if (b_bin !== exp_sync) begin n_fail++; $display("FAIL rnd_bin t=%0d: got %h want %h", t, b_bin, exp_sync); end
            n_checks++; if (b_chg !== exp_chg) begin n_fail++; $display("FAIL rnd_chg t=%0d: got %b want %b", t, b_chg, exp_chg); end
            n_checks++; if (b_merr !== exp_merr) begin n_fail++; $display("FAIL rnd_merr t=%0d: got %b want %b", t, b_merr, exp_merr); end
            n_checks++; if (b_ecnt !== 2'(cnt)) begin n_fail++; $display("FAIL rnd_ecnt t=%0d: got %0d want %0d", t, b_ecnt, cnt); end
            n_checks++; if (b_mcnt !== 2'd0) begin n_fail++; $display("FAIL rnd_mcnt t=%0d: got %0d want 0", t, b_mcnt); end
        end
        b_clr = 1'b0; b_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        a_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_in = 4'($urandom);
            @(negedge clk);
        end
        a_in = 4'hA; a_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (a_sync !== 4'h0) begin n_fail++; $display("FAIL mid_sync: got %h want 0", a_sync); end
        n_checks++; if (a_chg !== 1'b0) begin n_fail++; $display("FAIL mid_chg: got %b want 0", a_chg); end
        n_checks++; if (a_merr !== 1'b0) begin n_fail++; $display("FAIL mid_merr: got %b want 0", a_merr); end
        n_checks++; if (a_mcnt !== 16'd0) begin n_fail++; $display("FAIL mid_mcnt: got %0d want 0", a_mcnt); end
        n_checks++; if (a_ecnt !== 16'd0) begin n_fail++; $display("FAIL mid_ecnt: got %0d want 0", a_ecnt); end
        n_checks++; if (b_sync !== 4'h0) begin n_fail++; $display("FAIL mid_b_sync: got %h want 0", b_sync); end
        n_checks++; if (g_sync !== 4'h0) begin n_fail++; $display("FAIL mid_g_sync: got %h want 0", g_sync); end
        @(negedge clk);
        n_checks++; if (a_sync !== 4'h0) begin n_fail++; $display("FAIL mid_hold: got %h want 0", a_sync); end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (a_sync !== 4'h0) begin n_fail++; $display("FAIL mid_stale: got %h want 0", a_sync); end
        n_checks++; if (a_ecnt !== 16'd1) begin n_fail++; $display("FAIL mid_ecnt_rel: got %0d want 1", a_ecnt); end
        @(negedge clk);
        n_checks++; if (a_sync !== 4'hA) begin n_fail++; $display("FAIL mid_refill: got %h want A", a_sync); end
        n_checks++; if (a_chg !== 1'b1) begin n_fail++; $display("FAIL mid_chg_rel: got %b want 1", a_chg); end
        n_checks++; if (a_mcnt !== 16'd0) begin n_fail++; $display("FAIL mid_mcnt_rel: got %0d want 0", a_mcnt); end
    endtask

    initial begin
        test_reset();
        test_ideal_capture();
        test_latency();
        test_gray();
        test_multibit();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
